// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg: state encoding, ASCII constants and hex helpers for the USB command responder
package usb_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_EXEC,
        ST_LOAD,
        ST_RESP
    } state_t;

    localparam logic [7:0] C_CR = 8'h0D;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_SP = 8'h20;
    localparam logic [7:0] C_R  = 8'h52;
    localparam logic [7:0] C_W  = 8'h57;
    localparam logic [7:0] C_O  = 8'h4F;
    localparam logic [7:0] C_K  = 8'h4B;
    localparam logic [7:0] C_Q  = 8'h3F;

    function automatic logic [7:0] fold(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
    endfunction

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46);
    endfunction

    function automatic logic [3:0] hex2nib(input logic [7:0] b);
        return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/usb_cmd_tx_buf.sv
// usb_cmd_tx_buf: 4-byte reply buffer that streams its bytes out with valid/ready, holding data while stalled
module usb_cmd_tx_buf
    import usb_cmd_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [3:0][7:0] i_data,
    input  logic [2:0]      i_len,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [7:0]      o_data,
    output logic            o_done
);

    logic [3:0][7:0] r_buf;
    logic [1:0]      r_idx;
    logic [2:0]      r_len;
    logic            r_valid;

    assign o_valid = r_valid;
    assign o_data  = r_buf[r_idx];
    assign o_done  = r_valid && i_ready && ({1'b0, r_idx} == r_len - 3'd1);

    // capture a reply on load, then advance one byte per accepted transfer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_data;
            r_len   <= i_len;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            if (o_done) r_valid <= 1'b0;
            else r_idx <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/usb_cmd_responder.sv
// usb_cmd_responder: parses ASCII R/W command lines from the host and performs local register accesses
module usb_cmd_responder
    import usb_cmd_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 48000000
) (
    input  logic              clk_48mhz,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata
);

    localparam int NR = ADDR_W / 4;
    localparam int NW = NR + 2;
    localparam int CW = $clog2(NW + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = ADDR_W + 8;

    state_t          r_state, w_next;
    logic            r_run, r_is_w, r_err;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_acc;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      w_byte;
    logic            w_rx, w_digit, w_term, w_sp, w_len_ok, w_ok, w_tmo_hit, w_load, w_tx_done;
    logic [3:0][7:0] w_resp;
    logic [2:0]      w_len;

    assign w_byte    = fold(rx_data);
    assign w_rx      = rx_valid && rx_ready;
    assign w_digit   = is_hex(w_byte);
    assign w_term    = (w_byte == C_CR) || (w_byte == C_LF);
    assign w_sp      = (w_byte == C_SP);
    assign w_len_ok  = (r_cnt == (r_is_w ? CW'(NW) : CW'(NR)));
    assign w_ok      = !r_err && w_len_ok;
    assign w_tmo_hit = !w_rx && (r_tmo == TW'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    // next-state logic: parse bytes, execute, load reply, stream it out
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_rx && !w_term && !w_sp) w_next = ST_ARGS;
            ST_ARGS: w_next = (w_rx && w_term) ? ST_EXEC : w_tmo_hit ? ST_IDLE : ST_ARGS;
            ST_EXEC: w_next = ST_LOAD;
            ST_LOAD: w_next = ST_RESP;
            ST_RESP: if (w_tx_done) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // outputs: host back-pressure, register strobes and the reply contents
    always_comb begin
        rx_ready  = r_run && (r_state == ST_IDLE || r_state == ST_ARGS);
        reg_re    = (r_state == ST_EXEC) && w_ok && !r_is_w;
        reg_we    = (r_state == ST_EXEC) && w_ok && r_is_w;
        w_load    = (r_state == ST_LOAD);
        w_resp[0] = r_err ? C_Q : r_is_w ? C_O : nib2asc(reg_rdata[7:4]);
        w_resp[1] = r_err ? C_CR : r_is_w ? C_K : nib2asc(reg_rdata[3:0]);
        w_resp[2] = r_err ? C_LF : C_CR;
        w_resp[3] = r_err ? 8'h00 : C_LF;
        w_len     = r_err ? 3'd3 : 3'd4;
    end

    // line datapath: command type, digit accumulator, error flag, idle timer and latched register address/data
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            r_run     <= 1'b0;
            r_is_w    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_tmo     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_tmo <= '0;
                if (w_rx) begin
                    r_is_w <= (w_byte == C_W);
                    r_err  <= !(w_byte == C_R || w_byte == C_W);
                end
            end
            if (r_state == ST_ARGS) begin
                r_tmo <= w_rx ? '0 : (r_tmo == TW'(TIMEOUT)) ? r_tmo : r_tmo + 1'b1;
                if (w_rx && w_digit) begin
                    r_acc <= {r_acc[AW-5:0], hex2nib(w_byte)};
                    if (r_cnt <= CW'(NW)) r_cnt <= r_cnt + 1'b1;
                    if (r_cnt >= CW'(NW)) r_err <= 1'b1;
                end else if (w_rx && !w_term && !w_sp) begin
                    r_err <= 1'b1;
                end
                if (w_rx && w_term && w_ok) begin
                    reg_addr <= r_is_w ? r_acc[AW-1:8] : r_acc[ADDR_W-1:0];
                    if (r_is_w) reg_wdata <= r_acc[7:0];
                end
            end
            if (r_state == ST_EXEC && !w_len_ok) r_err <= 1'b1;
        end
    end

    usb_cmd_tx_buf u_tx_buf (
        .i_clk   (clk_48mhz),
        .i_rst_n (reset_n),
        .i_load  (w_load),
        .i_data  (w_resp),
        .i_len   (w_len),
        .i_ready (tx_ready),
        .o_valid (tx_valid),
        .o_data  (tx_data),
        .o_done  (w_tx_done)
    );

endmodule
